// File: rtl/branch_resolve_unit.sv
// Branch resolution: flags mispredictions and queues BHT/BTB training (BRANCH_RESOLVE_STAT_EN adds counters).
// Latency: recovery redirect and queued update both visible 1 cycle after accept.
// Backpressure: resolveReady drops while the update queue is full; updates drain on updValid && updReady.

package branchResolvePkg;
   localparam int ADDR_WIDTH = 32;

   typedef struct packed {
      logic                  isNextPcPredicted;
      logic [ADDR_WIDTH-1:0] predictedNextPC;
      logic                  isBranchTakenPredicted;
   } BranchPredict;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  taken;
      logic                  btbWrite;
      logic [ADDR_WIDTH-1:0] target;
   } UpdEntry;
endpackage

// Generic circular FIFO with registered occupancy; full never depends on a same-cycle read.
module syncFifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrValid,
   input  logic [WIDTH-1:0] wrData,
   input  logic             rdReady,
   output logic             rdValid,
   output logic [WIDTH-1:0] rdData,
   output logic             full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [CW-1:0]    count;
   logic             wrEn;
   logic             rdEn;

   assign full    = (count == FULL_COUNT);
   assign rdValid = (count != '0);
   assign rdData  = mem[rdPtr];
   assign wrEn    = wrValid && !full;
   assign rdEn    = rdReady && rdValid;

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrPtr] <= wrData;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (rdEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         unique case ({wrEn, rdEn})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module branch_resolve_unit
   import branchResolvePkg::*;
#(
   parameter int UPDATE_QUEUE_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  resolveValid,
   output logic                  resolveReady,
   input  logic [ADDR_WIDTH-1:0] resolvePc,
   input  logic                  resolveIsBranch,
   input  logic                  resolveTaken,
   input  logic [ADDR_WIDTH-1:0] resolveTarget,
   input  BranchPredict          resolvePredict,
   output logic                  recoverValid,
   output logic [ADDR_WIDTH-1:0] recoverPc,
   output logic                  updValid,
   input  logic                  updReady,
   output logic [ADDR_WIDTH-1:0] updPc,
   output logic                  updTaken,
   output logic                  updBtbWrite,
   output logic [ADDR_WIDTH-1:0] updTarget
`ifdef BRANCH_RESOLVE_STAT_EN
   ,
   output logic [31:0]           statBranchCount,
   output logic [31:0]           statMispredictCount
`endif
);
   UpdEntry               enqEntry;
   UpdEntry               headEntry;
   logic                  headValid;
   logic                  queueFull;
   logic                  branchAccept;
   logic                  targetHit;
   logic                  mispredict;
   logic [ADDR_WIDTH-1:0] redirectPc;

   assign resolveReady = !queueFull;
   assign branchAccept = resolveValid && resolveReady && resolveIsBranch;

   // A taken branch only counts as correctly predicted when fetch also had the right target.
   assign targetHit  = resolvePredict.isBranchTakenPredicted && resolvePredict.isNextPcPredicted
                       && (resolvePredict.predictedNextPC == resolveTarget);
   assign mispredict = resolveTaken ? !targetHit : resolvePredict.isBranchTakenPredicted;
   assign redirectPc = resolveTaken ? resolveTarget : resolvePc + ADDR_WIDTH'(4);

   always_comb begin
      enqEntry          = '0;
      enqEntry.pc       = resolvePc;
      enqEntry.taken    = resolveTaken;
      enqEntry.btbWrite = resolveTaken && !targetHit;
      enqEntry.target   = resolveTarget;
   end

   syncFifo #(
      .DEPTH (UPDATE_QUEUE_DEPTH),
      .WIDTH ($bits(UpdEntry))
   ) updQueue (
      .clk     (clk),
      .rst     (rst),
      .wrValid (branchAccept),
      .wrData  (enqEntry),
      .rdReady (updReady),
      .rdValid (headValid),
      .rdData  (headEntry),
      .full    (queueFull)
   );

   assign updValid    = headValid;
   assign updPc       = headValid ? headEntry.pc : '0;
   assign updTaken    = headValid && headEntry.taken;
   assign updBtbWrite = headValid && headEntry.btbWrite;
   assign updTarget   = headValid ? headEntry.target : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         recoverValid <= 1'b0;
         recoverPc    <= '0;
      end else begin
         recoverValid <= branchAccept && mispredict;
         if (branchAccept && mispredict) begin
            recoverPc <= redirectPc;
         end
      end
   end

`ifdef BRANCH_RESOLVE_STAT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         statBranchCount     <= '0;
         statMispredictCount <= '0;
      end else begin
         if (branchAccept) begin
            statBranchCount <= statBranchCount + 32'd1;
         end
         if (branchAccept && mispredict) begin
            statMispredictCount <= statMispredictCount + 32'd1;
         end
      end
   end
`else
   // No statistics hardware in this build.
`endif
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the fetch-stage branch prediction generator: it receives resolved branch outcomes together with the `BranchPredict` record carried down the pipeline from fetch. It detects mispredictions and issues a registered one-cycle recovery redirect. It also queues training updates for the BHT/BTB and drains them to the predictor tables over a valid/ready handshake.

## Interface
Parameters:
- `UPDATE_QUEUE_DEPTH`, 4: entries in the training update queue; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `resolveValid`  in  1  resolved instruction presented this cycle.
- `resolveReady`  out  1  block accepts the presented instruction.
- `resolvePc`  in  ADDR_WIDTH  PC of resolved instruction.
- `resolveIsBranch`  in  1  instruction is a conditional branch.
- `resolveTaken`  in  1  actual branch direction.
- `resolveTarget`  in  ADDR_WIDTH  actual taken target.
- `resolvePredict`  in  BranchPredict  fetch-time prediction record, with fields `isNextPcPredicted`, `predictedNextPC` and `isBranchTakenPredicted`.
- `recoverValid`  out  1  one-cycle pulse; fetch must redirect.
- `recoverPc`  out  ADDR_WIDTH  redirect PC.
- `updValid`  out  1  queue head is valid.
- `updReady`  in  1  predictor table write port free this cycle.
- `updPc`  out  ADDR_WIDTH  PC to train.
- `updTaken`  out  1  BHT training direction.
- `updBtbWrite`  out  1  write `updTarget` into the BTB entry for `updPc`.
- `updTarget`  out  ADDR_WIDTH  BTB target.

## Operation
- A handshake completes on `resolveValid && resolveReady`.
- `resolveReady = !full`. Full is computed from the registered occupancy, so it holds even when the queue dequeues in the same cycle. Non-branch instructions are also stalled while the queue is full.
- Misprediction is evaluated only for accepted instructions with `resolveIsBranch`:
  - Actual taken: mispredicted unless `isBranchTakenPredicted && isNextPcPredicted && predictedNextPC == resolveTarget`.
  - Actual not taken: mispredicted if `isBranchTakenPredicted`. `predictedNextPC` is ignored.
- A non-branch is never mispredicted and is never enqueued.
- Recovery PC is `resolveTarget` if taken, else `resolvePc + 4`. The add is modulo 2^ADDR_WIDTH, so wrap-around is silent.
- Every accepted branch enqueues one entry:
  - `pc` = `resolvePc`; `taken` = `resolveTaken`; `target` = `resolveTarget`.
  - `btbWrite` = `resolveTaken && !(isNextPcPredicted && isBranchTakenPredicted && predictedNextPC == resolveTarget)`.
- Queue: circular FIFO with read/write pointers and an occupancy counter 0..DEPTH. Pointers wrap at DEPTH.
  - Dequeue on `updValid && updReady`.
  - Enqueue and dequeue in the same cycle leave occupancy unchanged.
- `upd*` outputs are driven from the head entry. When the queue is empty, `updValid`=0 and `updPc`/`updTarget`/`updTaken`/`updBtbWrite` are 0.

## Timing
- Reset (`rst`=0 at a clock edge), including mid-operation:
  - All queue entries are dropped; pointers and occupancy go to 0.
  - `recoverValid`=0 and `recoverPc`=0.
  - `updValid`=0; `resolveReady`=1 from the cycle after reset.
- Recovery latency: `recoverValid` and `recoverPc` are registered and assert exactly 1 cycle after the accepting edge, for 1 cycle.
- Back-to-back mispredictions on consecutive accepts produce consecutive pulses, each carrying its own PC.
- Update latency: an entry appears on `updValid` the cycle after it is accepted. There is no same-cycle bypass.
- `upd*` outputs hold stable while `updValid && !updReady`.
- Throughput: one accept and one drain per cycle.

## Configuration
- `BRANCH_RESOLVE_STAT_EN` defined:
  - Adds outputs `statBranchCount` and `statMispredictCount`, both 32 bits, reset to 0.
  - Each counter increments on every accepted branch or every mispredicted branch, respectively, and wraps modulo 2^32.
- Undefined: the ports and counters are absent and the remaining behaviour is identical.

## Test plan
- Correctly predicted taken branch:
  - Stimulus: PC 0x100, taken, target 0x200, predict {TRUE, 0x200, TRUE}.
  - Response: no `recoverValid`; next cycle `updValid`=1, `updTaken`=1, `updBtbWrite`=0.
- Taken branch with BTB miss:
  - Stimulus: predict {FALSE, 0, TRUE}, target 0x340, PC 0x300.
  - Response: `recoverValid` pulse with `recoverPc`=0x340; update carries `updBtbWrite`=1, `updTarget`=0x340.
- Predicted taken, actually not taken:
  - Stimulus: PC 0x3FC, predict {TRUE, 0x500, TRUE}.
  - Response: `recoverPc`=0x400; `updTaken`=0, `updBtbWrite`=0.
- Full queue:
  - Stimulus: hold `updReady`=0 and accept 4 branches.
  - Response: `resolveReady`=0, including in the cycle where `updReady` rises. Entries then drain in order, one per cycle, and `resolveReady` returns to 1.
- Reset mid-operation:
  - Stimulus: queue at 3 entries and a mispredicted branch accepted in the cycle `rst`=0.
  - Response: no `recoverValid` pulse, `updValid`=0, and occupancy 0 afterwards.
- Non-branch and (with `BRANCH_RESOLVE_STAT_EN`) statistics:
  - Stimulus: non-branch with arbitrary predict fields, then 3 branches of which 1 mispredicts.
  - Response: the non-branch causes no recovery and no enqueue; `statBranchCount`=3, `statMispredictCount`=1.
